// File: rtl/msg_scheduler.sv
// Event-message scheduler: three request slots, fixed priority FIM > BPM > BDM, ASCII bytes out
// over a valid/ready handshake. Define MSG_NEWLINE_EN to append 0x0A after the closing '#'.
module msg_scheduler #(
    parameter int unsigned GAP_CYCLES = 4340
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       fim_req,
    input  logic [1:0] fim_unit,
    input  logic [3:0] fim_id,
    input  logic       bpm_req,
    input  logic [1:0] bpm_unit,
    input  logic [3:0] bpm_id,
    input  logic       bdm_req,
    input  logic [1:0] bdm_unit,
    input  logic [3:0] bdm_id,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [2:0] pend,
    output logic [2:0] overrun,
    input  logic       ovr_clr
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
`ifdef MSG_NEWLINE_EN
    localparam logic [3:0] TailLen = 4'd1;
`else
    localparam logic [3:0] TailLen = 4'd0;
`endif

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e          state;
    logic [2:0]      req_vec, grant, lost, accept;
    logic [1:0]      gnt_idx;
    logic [1:0]      unit_in   [3];
    logic [3:0]      id_in     [3];
    logic [1:0]      slot_unit [3];
    logic [3:0]      slot_id   [3];
    logic [1:0]      act_kind, act_unit;
    logic [3:0]      act_id, idx, last_idx;
    logic [GapW-1:0] gap_cnt;

    assign req_vec  = {bdm_req, bpm_req, fim_req};
    assign unit_in[0] = fim_unit;
    assign unit_in[1] = bpm_unit;
    assign unit_in[2] = bdm_unit;
    assign id_in[0]   = fim_id;
    assign id_in[1]   = bpm_id;
    assign id_in[2]   = bdm_id;
    assign busy       = (state != StIdle);

    // BPM/BDM insert a 'B' at position 8; remaining bytes shift by one relative to FIM.
    function automatic logic [7:0] msg_byte(input logic [1:0] kind, input logic [1:0] unit,
                                            input logic [3:0] id, input logic [3:0] pos);
        logic [3:0] j;
        msg_byte = 8'h00;
        j = (kind != 2'd0 && pos > 4'd8) ? pos - 4'd1 : pos;
        if (kind != 2'd0 && pos == 4'd8) begin
            msg_byte = "B";
        end else begin
            case (j)
                4'd0:    msg_byte = (kind == 2'd0) ? "F" : "B";
                4'd1:    msg_byte = (kind == 2'd0) ? "I" : (kind == 2'd1) ? "P" : "D";
                4'd2:    msg_byte = "M";
                4'd3:    msg_byte = "-";
                4'd4:    msg_byte = (unit == 2'd0) ? "E" : (unit == 2'd1) ? "C" : "R";
                4'd5:    msg_byte = "S";
                4'd6:    msg_byte = "U";
                4'd7:    msg_byte = "-";
                4'd8:    msg_byte = (id < 4'd10) ? 8'h30 + {4'h0, id} : 8'h3F;
                4'd9:    msg_byte = "-";
                4'd10:   msg_byte = "#";
                4'd11:   msg_byte = 8'h0A;
                default: msg_byte = 8'h00;
            endcase
        end
    endfunction

    always_comb begin
        grant   = 3'b000;
        gnt_idx = 2'd0;
        if (state == StIdle) begin
            if (pend[0]) begin
                grant   = 3'b001;
                gnt_idx = 2'd0;
            end else if (pend[1]) begin
                grant   = 3'b010;
                gnt_idx = 2'd1;
            end else if (pend[2]) begin
                grant   = 3'b100;
                gnt_idx = 2'd2;
            end
        end
        // A slot being granted this cycle is free to take a new request.
        lost     = req_vec & pend & ~grant;
        accept   = req_vec & ~lost;
        last_idx = ((act_kind == 2'd0) ? 4'd10 : 4'd11) + TailLen;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 3'b000;
            overrun <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                slot_unit[i] <= 2'd0;
                slot_id[i]   <= 4'd0;
            end
        end else begin
            pend    <= (pend & ~grant) | accept;
            overrun <= ovr_clr ? 3'b000 : (overrun | lost);
            for (int i = 0; i < 3; i++) begin
                if (accept[i]) begin
                    slot_unit[i] <= unit_in[i];
                    slot_id[i]   <= id_in[i];
                end
            end
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            idx      <= 4'd0;
            gap_cnt  <= '0;
            act_kind <= 2'd0;
            act_unit <= 2'd0;
            act_id   <= 4'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (|grant) begin
                        act_kind <= gnt_idx;
                        act_unit <= slot_unit[gnt_idx];
                        act_id   <= slot_id[gnt_idx];
                        idx      <= 4'd0;
                        tx_data  <= msg_byte(gnt_idx, 2'd0, 4'd0, 4'd0);
                        tx_valid <= 1'b1;
                        state    <= StSend;
                    end
                end
                StSend: begin
                    if (tx_ready) begin
                        if (idx == last_idx) begin
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            gap_cnt  <= '0;
                            state    <= (GAP_CYCLES == 0) ? StIdle : StGap;
                        end else begin
                            idx     <= idx + 4'd1;
                            tx_data <= msg_byte(act_kind, act_unit, act_id, idx + 4'd1);
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt == GapLast) begin
                        gap_cnt <= '0;
                        state   <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_scheduler.sv
// Bench for msg_scheduler: directed scenarios plus random traffic, all checked each cycle
// against a string-based message model.
module tb_msg_scheduler;

    localparam int unsigned GAP = 6;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       fim_req, bpm_req, bdm_req;
    logic [1:0] fim_unit, bpm_unit, bdm_unit;
    logic [3:0] fim_id, bpm_id, bdm_id;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, busy, ovr_clr;
    logic [2:0] pend, overrun;

    int checks = 0;
    int errors = 0;

    // Reference model: pending slots plus the text of the message in flight.
    bit [2:0]   m_pend;
    bit [1:0]   m_unit [3];
    bit [3:0]   m_id   [3];
    bit [2:0]   m_ovr;
    int         m_phase;  // 0 idle, 1 sending, 2 gap
    int         m_gap;
    int         m_pos;
    string      m_msg;

    msg_scheduler #(.GAP_CYCLES(GAP)) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .fim_req (fim_req),
        .fim_unit(fim_unit),
        .fim_id  (fim_id),
        .bpm_req (bpm_req),
        .bpm_unit(bpm_unit),
        .bpm_id  (bpm_id),
        .bdm_req (bdm_req),
        .bdm_unit(bdm_unit),
        .bdm_id  (bdm_id),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy),
        .pend    (pend),
        .overrun (overrun),
        .ovr_clr (ovr_clr)
    );

    always #10 clk_50M = ~clk_50M;

    function automatic string msg_text(int k, bit [1:0] u, bit [3:0] d);
        string s;
        if (k == 0) s = "FIM-";
        else if (k == 1) s = "BPM-";
        else s = "BDM-";
        if (u == 0) s = {s, "ESU"};
        else if (u == 1) s = {s, "CSU"};
        else s = {s, "RSU"};
        if (k == 0) s = {s, "-"};
        else s = {s, "-B"};
        s = {s, $sformatf("%c", (d < 10) ? 8'h30 + 8'(d) : 8'h3F), "-#"};
`ifdef MSG_NEWLINE_EN
        s = {s, "\n"};
`endif
        return s;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_ovr   = '0;
        m_phase = 0;
        m_gap   = 0;
        m_pos   = 0;
        m_msg   = "";
        for (int i = 0; i < 3; i++) begin
            m_unit[i] = '0;
            m_id[i]   = '0;
        end
    endtask

    task automatic model_edge();
        bit [2:0] req, old, lost;
        bit [1:0] u [3];
        bit [3:0] d [3];
        int g;
        req = {bdm_req, bpm_req, fim_req};
        u[0] = fim_unit; u[1] = bpm_unit; u[2] = bdm_unit;
        d[0] = fim_id;   d[1] = bpm_id;   d[2] = bdm_id;
        old  = m_pend;
        lost = '0;
        g    = -1;
        if (m_phase == 0) begin
            for (int i = 0; i < 3; i++) if (m_pend[i] && g < 0) g = i;
            if (g >= 0) begin
                m_msg     = msg_text(g, m_unit[g], m_id[g]);
                m_pos     = 0;
                m_phase   = 1;
                m_pend[g] = 1'b0;
            end
        end else if (m_phase == 1) begin
            if (tx_ready) begin
                m_pos++;
                if (m_pos == m_msg.len()) begin
                    if (GAP == 0) m_phase = 0;
                    else begin
                        m_phase = 2;
                        m_gap   = GAP;
                    end
                end
            end
        end else begin
            m_gap--;
            if (m_gap == 0) m_phase = 0;
        end
        for (int i = 0; i < 3; i++) begin
            if (req[i]) begin
                if (old[i] && g != i) lost[i] = 1'b1;
                else begin
                    m_pend[i] = 1'b1;
                    m_unit[i] = u[i];
                    m_id[i]   = d[i];
                end
            end
        end
        m_ovr = ovr_clr ? 3'b000 : (m_ovr | lost);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        chk("tx_valid", {7'd0, tx_valid}, {7'd0, m_phase == 1});
        if (m_phase == 1) chk("tx_data", tx_data, m_msg[m_pos]);
        chk("pend", {5'd0, pend}, {5'd0, m_pend});
        chk("overrun", {5'd0, overrun}, {5'd0, m_ovr});
        chk("busy", {7'd0, busy}, {7'd0, m_phase != 0});
    endtask

    task automatic step();
        @(posedge clk_50M);
        model_edge();
        #1;
        compare();
    endtask

    task automatic clear_reqs();
        fim_req = 1'b0;
        bpm_req = 1'b0;
        bdm_req = 1'b0;
        ovr_clr = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_pend", {5'd0, pend}, 8'd0);
        chk("rst_overrun", {5'd0, overrun}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        repeat (2) @(posedge clk_50M);
        @(negedge clk_50M);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_reqs();
        fim_unit = '0; fim_id = '0;
        bpm_unit = '0; bpm_id = '0;
        bdm_unit = '0; bdm_id = '0;
        tx_ready = 1'b1;
        apply_reset();

        // FIM-ESU-3-#
        fim_req = 1'b1; fim_unit = 2'd0; fim_id = 4'd3;
        step();
        clear_reqs();
        repeat (22) step();

        // Simultaneous BDM and FIM: FIM goes first
        bdm_req = 1'b1; bdm_unit = 2'd1; bdm_id = 4'd7;
        fim_req = 1'b1; fim_unit = 2'd2; fim_id = 4'd1;
        step();
        clear_reqs();
        repeat (45) step();

        // Back-pressure on byte 4 of BPM-ESU-B2-#
        bpm_req = 1'b1; bpm_unit = 2'd0; bpm_id = 4'd2;
        step();
        clear_reqs();
        repeat (4) step();
        tx_ready = 1'b0;
        repeat (5) step();
        tx_ready = 1'b1;
        repeat (22) step();

        // Second BPM request while the first waits behind a FIM
        fim_req = 1'b1; fim_unit = 2'd1; fim_id = 4'd5;
        step();
        clear_reqs();
        step();
        bpm_req = 1'b1; bpm_unit = 2'd0; bpm_id = 4'd2;
        step();
        clear_reqs();
        step();
        bpm_req = 1'b1; bpm_unit = 2'd2; bpm_id = 4'd9;
        step();
        clear_reqs();
        step();
        chk("overrun_bpm", {5'd0, overrun}, 8'h02);
        repeat (40) step();
        ovr_clr = 1'b1;
        step();
        clear_reqs();
        chk("overrun_cleared", {5'd0, overrun}, 8'h00);

        // Reset during byte 6 with a request pending
        fim_req = 1'b1; fim_unit = 2'd0; fim_id = 4'd8;
        step();
        clear_reqs();
        bdm_req = 1'b1; bdm_unit = 2'd3; bdm_id = 4'd4;
        step();
        clear_reqs();
        repeat (5) step();
        apply_reset();
        fim_req = 1'b1; fim_unit = 2'd1; fim_id = 4'd0;
        step();
        clear_reqs();
        repeat (22) step();

        // Out-of-range id
        bpm_req = 1'b1; bpm_unit = 2'd3; bpm_id = 4'd12;
        step();
        clear_reqs();
        repeat (24) step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            fim_req  = ($urandom_range(7) == 0);
            bpm_req  = ($urandom_range(7) == 0);
            bdm_req  = ($urandom_range(7) == 0);
            fim_unit = 2'($urandom); fim_id = 4'($urandom);
            bpm_unit = 2'($urandom); bpm_id = 4'($urandom);
            bdm_unit = 2'($urandom); bdm_id = 4'($urandom);
            tx_ready = ($urandom_range(3) != 0);
            ovr_clr  = ($urandom_range(31) == 0);
            step();
        end
        clear_reqs();
        tx_ready = 1'b1;
        repeat (100) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_scheduler.md
# msg_scheduler

Arbitrates event-message requests from the Energy, Communication and Research unit sections and serialises one ASCII message at a time toward the UART transmitter over a valid/ready byte handshake. It sits between the event sources (fault detector, electromagnet pick/drop logic) and the UART TX, and replaces per-section hand-sequenced text generation with one shared, queued sequencer.

## Interface
- GAP_CYCLES, 4340: idle cycles inserted after the last byte of each message; 0 means none.
- clk_50M  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- fim_req  in  1  single-cycle pulse: fault identified.
- fim_unit  in  2  section: 0 = ESU, 1 = CSU, 2 and 3 = RSU.
- fim_id  in  4  fault index, 0–9.
- bpm_req / bpm_unit / bpm_id  in  1/2/4  block picked; same encodings.
- bdm_req / bdm_unit / bdm_id  in  1/2/4  block dropped; same encodings.
- tx_data  out  8  ASCII byte to UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte this cycle.
- busy  out  1  high in SEND and GAP.
- pend  out  3  pending flags {bdm, bpm, fim}.
- overrun  out  3  sticky request-lost flags {bdm, bpm, fim}.
- ovr_clr  in  1  clears overrun. Has priority over a same-cycle set.

## Operation
- Three request slots, one per message type. Each slot holds a pending bit plus the captured unit and id.
- A req pulse while the slot is not pending sets pend and captures unit/id.
- A req pulse while the slot is already pending drops the new request and sets the matching overrun bit. The stored payload is kept.
- A req pulse in the same cycle as that slot's grant is accepted as a new pending request.
- Message formats:
  - FIM: "FIM-", unit text, "-", digit, "-#" (11 bytes).
  - BPM: "BPM-", unit text, "-B", digit, "-#" (12 bytes).
  - BDM: "BDM-", unit text, "-B", digit, "-#" (12 bytes).
- Unit text: "ESU", "CSU" or "RSU". Digit = 0x30 + id for id 0–9, and 0x3F ('?') for id 10–15.
- FSM states:
  - IDLE: if any pend bit is set, grant by fixed priority FIM > BPM > BDM. Copy the payload into active registers, clear that pend bit, set byte index to 0, go to SEND.
  - SEND: tx_valid = 1, tx_data = byte[index]. On tx_valid && tx_ready, increment index. On the last byte's handshake, go to GAP, or to IDLE if GAP_CYCLES = 0.
  - GAP: tx_valid = 0. Count GAP_CYCLES cycles, then go to IDLE.
- No preemption: a higher-priority request arriving mid-message waits for IDLE.
- Active payload is frozen during SEND. Input unit/id changes do not affect the message in flight.

## Timing
- Reset values: tx_data = 0x00, tx_valid = 0, busy = 0, pend = 0, overrun = 0, FSM = IDLE, gap counter = 0. Reset mid-message aborts immediately; a partial message is never resumed.
- Request latency: req in cycle n gives pend set in n+1. With the FSM idle, tx_valid rises with the first byte in n+2 and pend clears in n+2.
- tx_data stays stable while tx_valid && !tx_ready. tx_valid is never dropped before the handshake.
- Back-to-back bytes: one byte per cycle when tx_ready is held high. An 11-byte FIM occupies 11 SEND cycles.
- The gap lasts exactly GAP_CYCLES cycles. One IDLE cycle always separates messages.
- overrun and ovr_clr take effect one cycle after the event.

## Configuration
- MSG_NEWLINE_EN defined: append 0x0A after '#'. FIM becomes 12 bytes; BPM and BDM become 13.
- MSG_NEWLINE_EN undefined: messages end at '#' and no 0x0A is ever emitted.

## Test plan
- fim_req with unit 0, id 3, tx_ready = 1: bytes "FIM-ESU-3-#" (46 49 4D 2D 45 53 55 2D 33 2D 23), tx_valid high for 11 consecutive cycles starting 2 cycles after the req.
- bdm_req (unit 1, id 7) and fim_req (unit 2, id 1) in the same cycle: "FIM-RSU-1-#" is sent first, then GAP_CYCLES idle cycles plus one IDLE cycle, then "BDM-CSU-B7-#".
- Hold tx_ready low 5 cycles on byte 4 of "BPM-ESU-B2-#": tx_data holds 0x2D, tx_valid stays high, and no bytes are duplicated or lost.
- Two bpm_req pulses while the first is still pending (bpm_id 2, then bpm_id 9): overrun = 3'b010 and the message carries '2'. After ovr_clr, overrun = 0.
- rst_n low during byte 6: tx_valid = 0 immediately and pend = 0. A new fim_req after release produces a complete message from 'F'.
- bpm_id = 12: the digit is sent as 0x3F. With MSG_NEWLINE_EN defined, the last byte is 0x0A.
